sha1_msg_padder: RTL and testbench
==================================

# sha1_msg_padder

Upstream feeder for the tree SHA-1 core. It accepts a message as a stream of 32-bit big-endian words and applies SHA-1 padding: a 0x80 marker, zero fill, and a 64-bit bit length. It presents the result as one 512-bit block on `msg` and pulses `start` only when the core reports not busy. Messages are limited to 1–55 bytes, so every message fits one block; longer messages are discarded with an error pulse. A double buffer (build buffer plus output register) lets the next message stream in while the core is still busy.

## Interface
- No parameters. Maximum message length is fixed at 55 bytes.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  32  message word; first byte in bits [31:24].
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_last`  in  1  final word of the message; qualified by `in_valid`.
- `in_bytes`  in  2  valid bytes in the last word (0 means 4, 1–3 literal); ignored when `in_last` is 0.
- `in_ready`  out  1  padder accepts a word this cycle.
- `busy`  in  1  core busy flag, driven by the core's `busy` output.
- `msg`  out  512  padded block; word 0 in bits [511:480].
- `start`  out  1  one-cycle request to the core to consume `msg`.
- `err`  out  1  one-cycle pulse when a message longer than 55 bytes has been dropped.

## Operation
- Build FSM states:
  - FILL: `in_ready`=1. Each accepted word is written to build word `wcnt`, and the 6-bit byte count `bcnt` advances by 4, or by `in_bytes` on the last word.
  - FULL: build buffer complete and waiting for the output register. `in_ready`=0.
  - DROP: `in_ready`=1; accepted words are discarded until `in_last`.
- Padding is applied on acceptance of the last word, giving total length L:
  - unused byte lanes of that word are forced to 0;
  - byte L = 0x80;
  - bytes L+1..55 = 0;
  - bits [63:0] = L×8, which is zero-extended and never exceeds 440.
- Overflow: if an accepted word would push the total above 55 bytes, the FSM enters DROP and words are discarded.
  - If that word is itself `in_last`, `err` pulses next cycle and the FSM returns to FILL with the build buffer cleared.
  - Otherwise, on the `in_last` word accepted in DROP: `err` pulses the next cycle and the FSM returns to FILL with the build buffer cleared.
  - No `start` is issued for a dropped message.
- Issue FSM states:
  - OIDLE: when the build side is FULL, copy build → `msg` and release the build side to FILL in the same cycle. Go to OREQ.
  - OREQ: when `busy`=0, assert `start` for one cycle and go to OACK.
  - OACK: wait until `busy`=1, confirming the core accepted the block, then go to OIDLE.
- `msg` changes only on the OIDLE copy. It is stable from the copy through the whole busy period.
- An `in_last` word with `in_bytes`=0 and a count that lands exactly on 56 bytes is an overflow.

## Timing
- Reset values (asynchronous assertion):
  - `msg`=0, `start`=0, `err`=0;
  - build FSM in FILL with the build buffer and counters cleared, so `in_ready`=1 during reset;
  - issue FSM in OIDLE.
- Latency, last word accepted at edge T:
  - FULL from T+1;
  - `msg` loaded at T+2 if the issue FSM is in OIDLE;
  - `start` high during cycle T+3 at the earliest (if `busy`=0).
- `start` is never asserted while `busy`=1. Exactly one `start` is issued per valid message.
- While a block waits in OREQ/OACK, a second message may fill. It then holds in FULL with `in_ready`=0 until the issue FSM returns to OIDLE.
- `busy` is sampled as a registered input. There is no combinational path from `busy` to `start`.
- `reset` asserted mid-fill or mid-issue: all state clears immediately, partial data is lost, and no `start` or `err` occurs after release.
- `in_valid` with `in_ready`=0: the word is not consumed. The source must hold it.

## Test plan
- "abc": `in_data`=0x61626300, `in_bytes`=3, `in_last`=1, `busy`=0.
  - Required: `msg`[511:480]=0x61626380, `msg`[63:0]=0x18, all other bits 0.
  - Required: one `start` pulse at T+3.
  - With the core attached: hash = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- 55 bytes (13 full words, then a last word with `in_bytes`=3). Required:
  - `msg` bits [71:64]=0x80;
  - `msg`[63:0]=0x1B8;
  - one `start`.
- 56 bytes (14 words, last with `in_bytes`=0). Required:
  - one `err` pulse;
  - no `start`;
  - `in_ready`=1 afterwards;
  - a following "abc" message processes correctly.
- Hold `busy`=1 for 40 cycles. Send message A, then message B. Required:
  - `start` for A only after `busy` falls;
  - B fills, then `in_ready`=0;
  - `msg` stays equal to A until the copy of B, which occurs after `busy` has risen following A's `start`.
- Assert `reset` after 3 words of a 10-word message. Required:
  - outputs zero;
  - no `start`;
  - a subsequent 4-byte message 0x61626364 gives `msg`[511:448]=0x6162636480000000 and length 0x20.
- Random back-to-back messages of 1–60 bytes against a padding model, with `busy` toggled randomly. Check:
  - `start` count equals the number of valid messages;
  - `err` count equals the number of messages over 55 bytes;
  - every block matches the model.

Source files
------------

// File: rtl/sha1_msg_padder.sv
// sha1_msg_padder
//   Feeds the SHA-1 core. Collects a message of 1..55 bytes arriving as
//   32-bit big-endian words, applies SHA-1 padding (0x80 marker, zero fill,
//   64-bit bit length) and presents the single resulting 512-bit block on
//   msg, pulsing start once the core is not busy. Longer messages are
//   discarded with a one-cycle err pulse. A build buffer plus the msg output
//   register let the next message stream in while the core is busy.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_data   message word, first byte in [31:24]
//   in_valid  in_data valid this cycle
//   in_last   final word of the message (qualified by in_valid)
//   in_bytes  valid bytes in the last word (0 means 4)
//   in_ready  padder accepts a word this cycle
//   busy      core busy flag
//   msg       padded block, word 0 in [511:480]
//   start     one-cycle request to the core to consume msg
//   err       one-cycle pulse when an over-length message was dropped
module sha1_msg_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         in_ready,
    input  logic         busy,
    output logic [511:0] msg,
    output logic         start,
    output logic         err
);

    typedef enum logic [1:0] {FILL, FULL, DROP} build_state_t;
    typedef enum logic [1:0] {OIDLE, OREQ, OACK} issue_state_t;

    build_state_t bstate;
    issue_state_t istate;

    logic [511:0] blk;
    logic [3:0]   wcnt;
    logic [5:0]   bcnt;
    logic         busy_r;

    logic         accept;
    logic         copy;
    logic         overflow;
    logic [2:0]   add;
    logic [6:0]   total;
    logic [31:0]  lane_mask;
    logic [8:0]   wbase;
    logic [8:0]   pbase;
    logic [511:0] blk_word;
    logic [511:0] blk_pad;

    assign in_ready = (bstate != FULL);
    assign accept   = in_valid && in_ready;
    // Output register takes the completed block and frees the build side
    // in the same cycle.
    assign copy     = (istate == OIDLE) && (bstate == FULL);

    always_comb begin
        add = (in_last && (in_bytes != 2'd0)) ? {1'b0, in_bytes} : 3'd4;
        total = {1'b0, bcnt} + {4'b0, add};
        overflow = (total > 7'd55);

        lane_mask = '1;
        if (in_last) begin
            case (in_bytes)
                2'd1:    lane_mask = 32'hFF00_0000;
                2'd2:    lane_mask = 32'hFFFF_0000;
                2'd3:    lane_mask = 32'hFFFF_FF00;
                default: lane_mask = '1;
            endcase
        end

        wbase = 9'd511 - {wcnt, 5'b0};
        pbase = 9'd511 - {total[5:0], 3'b0};

        blk_word = blk;
        blk_word[wbase -: 32] = in_data & lane_mask;

        // The buffer is all-zero beyond the written words, so only the
        // marker byte and the length field need to be added.
        blk_pad = blk_word;
        blk_pad[pbase -: 8] = 8'h80;
        blk_pad[63:0] = {54'b0, total, 3'b0};
    end

    // Build side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bstate <= FILL;
            blk    <= '0;
            wcnt   <= '0;
            bcnt   <= '0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (copy) begin
                bstate <= FILL;
                blk    <= '0;
                wcnt   <= '0;
                bcnt   <= '0;
            end else begin
                case (bstate)
                    FILL: begin
                        if (accept) begin
                            if (overflow) begin
                                blk  <= '0;
                                wcnt <= '0;
                                bcnt <= '0;
                                if (in_last) begin
                                    err <= 1'b1;
                                end else begin
                                    bstate <= DROP;
                                end
                            end else if (in_last) begin
                                blk    <= blk_pad;
                                bcnt   <= total[5:0];
                                wcnt   <= wcnt + 4'd1;
                                bstate <= FULL;
                            end else begin
                                blk  <= blk_word;
                                bcnt <= total[5:0];
                                wcnt <= wcnt + 4'd1;
                            end
                        end
                    end
                    DROP: begin
                        if (accept && in_last) begin
                            err    <= 1'b1;
                            bstate <= FILL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            istate <= OIDLE;
            msg    <= '0;
            start  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            busy_r <= busy;
            start  <= 1'b0;
            case (istate)
                OIDLE: begin
                    if (copy) begin
                        msg    <= blk;
                        istate <= OREQ;
                    end
                end
                OREQ: begin
                    if (!busy_r) begin
                        start  <= 1'b1;
                        istate <= OACK;
                    end
                end
                OACK: begin
                    if (busy_r) begin
                        istate <= OIDLE;
                    end
                end
                default: istate <= OIDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb_sha1_msg_padder
//   Self-checking bench for sha1_msg_padder: a table of directed messages,
//   hand sequences for start latency, busy back-pressure and mid-message
//   reset, and a random back-to-back run against a byte-level padding model.
module tb_sha1_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         in_ready;
    logic         busy;
    logic [511:0] msg;
    logic         start;
    logic         err;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Simple core stand-in: busy for core_len cycles after each start,
    // optionally held high by hold_busy.
    logic hold_busy = 1'b0;
    int   core_len  = 3;
    int   core_left = 0;
    always @(posedge clk) begin
        if (start) core_left <= core_len;
        else if (core_left > 0) core_left <= core_left - 1;
    end
    assign busy = hold_busy | (core_left != 0);

    sha1_msg_padder dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_bytes (in_bytes),
        .in_ready (in_ready),
        .busy     (busy),
        .msg      (msg),
        .start    (start),
        .err      (err)
    );

    typedef logic [7:0] bq_t[$];

    logic [511:0] exp_q[$];
    logic [511:0] last_msg = '0;
    int start_cnt = 0;
    int err_cnt   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start) begin
            start_cnt++;
            last_msg = msg;
            check_int("start_while_busy", int'(busy), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual=%0h required=none", msg);
            end else begin
                check("block", msg, exp_q.pop_front());
            end
        end
        if (err) err_cnt++;
    end

    function automatic logic [511:0] pad_model(input bq_t b);
        logic [511:0] r;
        int n;
        r = '0;
        n = b.size();
        for (int i = 0; i < n; i++) r[511-8*i -: 8] = b[i];
        r[511-8*n -: 8] = 8'h80;
        r[63:0] = 64'(n * 8);
        return r;
    endfunction

    function automatic bq_t mk(input int n, input logic [7:0] base);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        return q;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Unused lanes of the last word carry 0xEE so lane masking is exercised.
    task automatic send_msg(input bq_t b);
        int n;
        int nw;
        int idx;
        logic [31:0] d;
        n  = b.size();
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) begin
                idx = 4 * w + k;
                d[31-8*k -: 8] = (idx < n) ? b[idx] : 8'hEE;
            end
            send_word(d, (w == nw - 1), 2'(n % 4));
        end
    endtask

    task automatic wait_for(input int s_tgt, input int e_tgt, input int limit, input string name);
        int t;
        t = 0;
        while ((start_cnt < s_tgt || err_cnt < e_tgt) && t < limit) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (start_cnt < s_tgt || err_cnt < e_tgt) begin
            errors++;
            $display("FAIL %s timeout starts=%0d required=%0d errs=%0d required=%0d",
                     name, start_cnt, s_tgt, err_cnt, e_tgt);
        end
    endtask

    typedef struct {
        int          n;
        logic [7:0]  base;
        logic [31:0] w0;
        logic [63:0] len;
        logic        e;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int s0;
        int e0;
        int valid_cnt;
        int over_cnt;
        int n;
        bq_t b;
        logic [511:0] ma;

        tbl[0]  = '{1,  8'h10, 32'h1080_0000, 64'h8,   1'b0};
        tbl[1]  = '{2,  8'h10, 32'h1011_8000, 64'h10,  1'b0};
        tbl[2]  = '{3,  8'h10, 32'h1011_1280, 64'h18,  1'b0};
        tbl[3]  = '{4,  8'h10, 32'h1011_1213, 64'h20,  1'b0};
        tbl[4]  = '{5,  8'h10, 32'h1011_1213, 64'h28,  1'b0};
        tbl[5]  = '{8,  8'h10, 32'h1011_1213, 64'h40,  1'b0};
        tbl[6]  = '{54, 8'h10, 32'h1011_1213, 64'h1B0, 1'b0};
        tbl[7]  = '{55, 8'h10, 32'h1011_1213, 64'h1B8, 1'b0};
        tbl[8]  = '{56, 8'h10, 32'h0,         64'h0,   1'b1};
        tbl[9]  = '{3,  8'h61, 32'h6162_6380, 64'h18,  1'b0};
        tbl[10] = '{60, 8'h10, 32'h0,         64'h0,   1'b1};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        in_bytes = '0;
        #1;
        check("reset_msg", msg, '0);
        check_int("reset_start", int'(start), 0);
        check_int("reset_err", int'(err), 0);
        check_int("reset_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        for (int v = 0; v < 11; v++) begin
            s0 = start_cnt;
            e0 = err_cnt;
            b  = mk(tbl[v].n, tbl[v].base);
            if (!tbl[v].e) exp_q.push_back(pad_model(b));
            send_msg(b);
            idle();
            wait_for(s0 + (tbl[v].e ? 0 : 1), e0 + (tbl[v].e ? 1 : 0), 40, "table_wait");
            repeat (8) @(negedge clk);
            check_int("table_starts", start_cnt - s0, tbl[v].e ? 0 : 1);
            check_int("table_errs", err_cnt - e0, tbl[v].e ? 1 : 0);
            if (tbl[v].e) begin
                check_int("table_ready_after_err", int'(in_ready), 1);
            end else begin
                check("table_word0", 512'(last_msg[511:480]), 512'(tbl[v].w0));
                check("table_len", 512'(last_msg[63:0]), 512'(tbl[v].len));
                if (tbl[v].n == 55) check("table_marker55", 512'(last_msg[71:64]), 512'(8'h80));
            end
        end

        // "abc" latency: accept at T, FULL at T+1, msg at T+2, start at T+3
        ma = pad_model(mk(3, 8'h61));
        exp_q.push_back(ma);
        send_word(32'h6162_6300, 1'b1, 2'd3);
        idle();
        check_int("abc_full_ready", int'(in_ready), 0);
        check_int("abc_t1_start", int'(start), 0);
        @(negedge clk);
        check("abc_t2_msg", msg, ma);
        check_int("abc_t2_start", int'(start), 0);
        @(negedge clk);
        check_int("abc_t3_start", int'(start), 1);
        repeat (10) @(negedge clk);

        // Busy held high: A waits in the output register, B fills and holds
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        s0 = start_cnt;
        ma = pad_model(mk(3, 8'h61));
        exp_q.push_back(ma);
        exp_q.push_back(pad_model(mk(8, 8'h20)));
        send_msg(mk(3, 8'h61));
        idle();
        repeat (4) @(negedge clk);
        check("hold_msg_a", msg, ma);
        send_msg(mk(8, 8'h20));
        idle();
        repeat (3) @(negedge clk);
        check_int("hold_b_full", int'(in_ready), 0);
        repeat (25) @(negedge clk);
        check("hold_msg_still_a", msg, ma);
        check_int("hold_no_start", start_cnt - s0, 0);
        core_len  = 4;
        hold_busy = 1'b0;
        wait_for(s0 + 1, 0, 40, "hold_start_a");
        @(negedge clk);
        check("hold_msg_a_after_start", msg, ma);
        check_int("hold_b_still_held", int'(in_ready), 0);
        wait_for(s0 + 2, 0, 60, "hold_start_b");
        repeat (10) @(negedge clk);

        // Reset in the middle of a message
        send_word(32'h0101_0101, 1'b0, 2'd0);
        send_word(32'h0202_0202, 1'b0, 2'd0);
        send_word(32'h0303_0303, 1'b0, 2'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_msg", msg, '0);
        check_int("rst_start", int'(start), 0);
        check_int("rst_err", int'(err), 0);
        check_int("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = start_cnt;
        e0 = err_cnt;
        repeat (10) @(negedge clk);
        check_int("rst_no_start", start_cnt - s0, 0);
        check_int("rst_no_err", err_cnt - e0, 0);
        exp_q.push_back(pad_model(mk(4, 8'h61)));
        send_word(32'h6162_6364, 1'b1, 2'd0);
        idle();
        wait_for(s0 + 1, 0, 40, "rst_after_msg");
        check("rst_after_head", 512'(last_msg[511:448]), 512'(64'h6162_6364_8000_0000));
        check("rst_after_len", 512'(last_msg[63:0]), 512'(64'h20));
        repeat (10) @(negedge clk);

        // Random back-to-back messages
        s0 = start_cnt;
        e0 = err_cnt;
        valid_cnt = 0;
        over_cnt  = 0;
        for (int m = 0; m < 40; m++) begin
            n = $urandom_range(1, 60);
            core_len = $urandom_range(1, 6);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
            if (n <= 55) begin
                exp_q.push_back(pad_model(b));
                valid_cnt++;
            end else begin
                over_cnt++;
            end
            send_msg(b);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end
        idle();
        wait_for(s0 + valid_cnt, e0 + over_cnt, 3000, "rand_drain");
        repeat (10) @(negedge clk);
        check_int("rand_starts", start_cnt - s0, valid_cnt);
        check_int("rand_errs", err_cnt - e0, over_cnt);
        check_int("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
